// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: decode/EXU issue handshake plus writeback retire port of the issue scoreboard
interface issue_scoreboard_if;
  logic       valid_i;
  logic       ready_o;
  logic       rena1_i;
  logic [4:0] raddr1_i;
  logic       rena2_i;
  logic [4:0] raddr2_i;
  logic       wena_i;
  logic [4:0] waddr_i;
  logic       serial_i;
  logic       flush_i;
  logic       valid_o;
  logic       ready_i;
  logic       wb_valid_i;
  logic [4:0] wb_waddr_i;
  logic       idle_o;
  logic       err_o;
  modport master (
    output valid_i, rena1_i, raddr1_i, rena2_i, raddr2_i, wena_i, waddr_i, serial_i, flush_i,
    output ready_i, wb_valid_i, wb_waddr_i,
    input  ready_o, valid_o, idle_o, err_o
  );
  modport slave (
    input  valid_i, rena1_i, raddr1_i, rena2_i, raddr2_i, wena_i, waddr_i, serial_i, flush_i,
    input  ready_i, wb_valid_i, wb_waddr_i,
    output ready_o, valid_o, idle_o, err_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: holds decoded instrs on RAW/WAW hazards, in-flight limit or pending serial drain.
// SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback relieve the hold.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input logic clk,
  input logic rst,
  issue_scoreboard_if.slave bus
);
  logic [31:1]      busy, busy_eff, set_oh, clr_oh;
  logic [31:0]      bz, br;
  logic [CNT_W-1:0] cnt;
  logic             err, wr, hazard, full, idle_eff, hold, inc, dec, bad_wb, ovf;
  function automatic logic [31:1] onehot(input logic [4:0] a);
    for (int i = 1; i < 32; i++) onehot[i] = (a == 5'(i));
  endfunction
  assign clr_oh = {31{bus.wb_valid_i}} & onehot(bus.wb_waddr_i);
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign busy_eff = busy & ~clr_oh;
  assign idle_eff = (cnt == '0) || (cnt == CNT_W'(1) && bus.wb_valid_i);
`else
  assign busy_eff = busy;
  assign idle_eff = (cnt == '0);
`endif
  // bit 0 stands for x0, which is never busy
  assign bz = {busy_eff, 1'b0};
  assign br = {busy, 1'b0};
  assign wr = bus.wena_i & (bus.waddr_i != '0);
  assign hazard = (bus.rena1_i & bz[bus.raddr1_i]) | (bus.rena2_i & bz[bus.raddr2_i]) | (bus.wena_i & bz[bus.waddr_i]);
  assign full = wr & (cnt == CNT_W'(MAX_INFLIGHT)) & ~bus.wb_valid_i;
  assign hold = hazard | full | (bus.serial_i & ~idle_eff);
  assign bus.valid_o = bus.valid_i & ~bus.flush_i & ~hold;
  assign bus.ready_o = bus.flush_i | (bus.ready_i & ~hold);
  assign bus.idle_o = (cnt == '0);
  assign bus.err_o = err;
  assign inc = bus.valid_o & bus.ready_i & wr;
  assign dec = bus.wb_valid_i & (cnt != '0);
  assign set_oh = {31{inc}} & onehot(bus.waddr_i);
  // x0 retires are legal while something is in flight; any other retire must hit a busy reg
  assign bad_wb = bus.wb_valid_i & ((cnt == '0) | ((bus.wb_waddr_i != '0) & ~br[bus.wb_waddr_i]));
  assign ovf = inc & ~dec & (cnt == CNT_W'(MAX_INFLIGHT));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_oh) | set_oh;
      cnt  <= cnt + CNT_W'(inc) - CNT_W'(dec);
      err  <= err | bad_wb | ovf;
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: table-driven per-cycle vectors plus hand sequences for bypass and mid-stall reset
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  issue_scoreboard_if bus ();
  issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int v, r1e, r1, r2e, r2, we, wa, ser, fl, rdy, wbv, wba;
    int evo, ero, eidle, eerr;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t r);
    bus.valid_i    = r.v[0];
    bus.rena1_i    = r.r1e[0];
    bus.raddr1_i   = r.r1[4:0];
    bus.rena2_i    = r.r2e[0];
    bus.raddr2_i   = r.r2[4:0];
    bus.wena_i     = r.we[0];
    bus.waddr_i    = r.wa[4:0];
    bus.serial_i   = r.ser[0];
    bus.flush_i    = r.fl[0];
    bus.ready_i    = r.rdy[0];
    bus.wb_valid_i = r.wbv[0];
    bus.wb_waddr_i = r.wba[4:0];
  endtask
  task automatic outs(input string tag, input int evo, input int ero, input int eidle, input int eerr);
    chk({tag, "_valid_o"}, 32'(bus.valid_o), evo);
    chk({tag, "_ready_o"}, 32'(bus.ready_o), ero);
    chk({tag, "_idle_o"}, 32'(bus.idle_o), eidle);
    chk({tag, "_err_o"}, 32'(bus.err_o), eerr);
  endtask
  function automatic vec_t idle_in();
    return '{0,0,0,0,0,0,0,0,0,1,0,0, 0,1,1,0};
  endfunction
  initial begin
    int exp_bypass;
    //             v r1e r1 r2e r2 we wa ser fl rdy wbv wba  vo ro idle err
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0}); // 0 empty
    vecs.push_back('{1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0,   1, 1, 1, 0}); // 1 add x5
    vecs.push_back('{1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 0, 0,   0, 0, 0, 0}); // 2 addi x6,x5 RAW
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5,   0, 1, 0, 0}); // 3 retire x5
    vecs.push_back('{1, 1, 5, 0, 0, 1, 6, 0, 0, 1, 0, 0,   1, 1, 1, 0}); // 4 addi now issues
    vecs.push_back('{1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0,   1, 0, 0, 0}); // 5 EXU not ready
    vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0,   1, 1, 0, 0}); // 6 x1
    vecs.push_back('{1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0,   1, 1, 0, 0}); // 7 x2
    vecs.push_back('{1, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0,   1, 1, 0, 0}); // 8 x3 -> cnt 4
    vecs.push_back('{1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0,   0, 0, 0, 0}); // 9 full
    vecs.push_back('{1, 1, 8, 1, 9, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0}); // 10 sw x8,x9 passes
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0}); // 11 write x0 not counted
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0}); // 12 rs2 RAW x1
    vecs.push_back('{1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0,   0, 0, 0, 0}); // 13 WAW x2
    vecs.push_back('{1, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 0, 0}); // 14 flush hazarded
    vecs.push_back('{1, 0, 0, 0, 0, 1, 7, 0, 0, 1, 1, 6,   1, 1, 0, 0}); // 15 full relieved by wb
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0}); // 16 serial held
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 1, 0, 0}); // 17 retire x1
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2,   0, 1, 0, 0}); // 18 retire x2
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3,   0, 1, 0, 0}); // 19 retire x3
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0}); // 20 serial, cnt 1
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7,   0, 1, 0, 0}); // 21 retire x7
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,   1, 1, 1, 0}); // 22 serial issues
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9,   0, 1, 1, 0}); // 23 wb non-busy x9
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 1}); // 24 err sticky
    vecs.push_back('{1, 1, 9, 0, 0, 1, 4, 0, 0, 1, 0, 0,   1, 1, 1, 1}); // 25 x9 not busy after bad wb
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4,   0, 1, 0, 1}); // 26 retire x4
    drive(idle_in());
    #2;
    outs("reset", 0, 1, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      outs($sformatf("row%0d", i), vecs[i].evo, vecs[i].ero, vecs[i].eidle, vecs[i].eerr);
      @(posedge clk);
      #1;
    end
    // dependent instr whose producer retires in the same cycle
    drive('{1,0,0,0,0,1,5,0,0,1,0,0, 0,0,0,0});
    #1;
    chk("byp_prod_valid_o", 32'(bus.valid_o), 1);
    @(posedge clk);
    #1;
    drive('{1,1,5,0,0,0,0,0,0,1,1,5, 0,0,0,0});
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    exp_bypass = 1;
`else
    exp_bypass = 0;
`endif
    chk("byp_dep_valid_o", 32'(bus.valid_o), exp_bypass);
    chk("byp_dep_ready_o", 32'(bus.ready_o), exp_bypass);
    @(posedge clk);
    #1;
    drive('{1,1,5,0,0,0,0,0,0,1,0,0, 0,0,0,0});
    #1;
    chk("byp_after_valid_o", 32'(bus.valid_o), 1);
    chk("byp_after_idle_o", 32'(bus.idle_o), 1);
    @(posedge clk);
    #1;
    // reset asserted in the middle of a RAW stall
    drive('{1,0,0,0,0,1,5,0,0,1,0,0, 0,0,0,0});
    @(posedge clk);
    #1;
    drive('{1,1,5,0,0,0,0,0,0,1,0,0, 0,0,0,0});
    #1;
    chk("stall_valid_o", 32'(bus.valid_o), 0);
    chk("stall_idle_o", 32'(bus.idle_o), 0);
    chk("stall_err_o", 32'(bus.err_o), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_idle_o", 32'(bus.idle_o), 1);
    chk("rst_mid_err_o", 32'(bus.err_o), 0);
    chk("rst_mid_valid_o", 32'(bus.valid_o), 1);
    chk("rst_mid_ready_o", 32'(bus.ready_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('{0,0,0,0,0,0,0,0,0,1,1,5, 0,0,0,0});
    #1;
    chk("late_wb_err_pre", 32'(bus.err_o), 0);
    @(posedge clk);
    #1;
    drive(idle_in());
    #1;
    chk("late_wb_err_o", 32'(bus.err_o), 1);
    chk("late_wb_idle_o", 32'(bus.idle_o), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
